// File: rtl/mskg4mul_sched.sv
// Round-robin scheduler sharing one HPC3 masked G(4) multiplier between NREQ requesters.
// Optional feature macro: MSKG4_SCHED_IDLE_ZERO_EN (zero gadget inputs on idle cycles).
module mskg4mul_sched #(
  parameter int d    = 2,
  parameter int NREQ = 2,
  parameter int TW   = 2,
  parameter int RW   = 4 * (d * (d - 1) / 2) * 2,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*d-1:0]    req_a0,
  input  logic [NREQ*d-1:0]    req_a1,
  input  logic [NREQ*d-1:0]    req_b0,
  input  logic [NREQ*d-1:0]    req_b1,
  input  logic [NREQ*TW-1:0]   req_tag,
  input  logic [RW-1:0]        rnd_in,
  input  logic                 rnd_valid,
  output logic                 rnd_ready,
  output logic [d-1:0]         mul_ina0,
  output logic [d-1:0]         mul_ina1,
  output logic [d-1:0]         mul_inb0,
  output logic [d-1:0]         mul_inb1,
  output logic [d-1:0]         mul_ina0_prev,
  output logic [d-1:0]         mul_ina1_prev,
  output logic [RW-1:0]        mul_rnd,
  input  logic [d-1:0]         mul_out0,
  input  logic [d-1:0]         mul_out1,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [d-1:0]         out0,
  output logic [d-1:0]         out1,
  output logic [IDW-1:0]       out_id,
  output logic [TW-1:0]        out_tag
);

  localparam int EW = 2 * d + IDW + TW;

  logic [IDW-1:0]    ptr_q, ptr_d;
  logic              inflight_q, inflight_d;
  logic [IDW-1:0]    fl_id_q, fl_id_d;
  logic [TW-1:0]     fl_tag_q, fl_tag_d;
  logic [d-1:0]      ina0_prev_q, ina0_prev_d, ina1_prev_q, ina1_prev_d;
  logic [EW-1:0]     slot0_q, slot0_d, slot1_q, slot1_d;
  logic [1:0]        count_q, count_d;

  logic [2*NREQ-1:0] req_dbl, req_rot_full;
  logic [NREQ-1:0]   req_rot;
  logic [IDW-1:0]    winner, sel;
  logic              any_req, issue, push, pop;
  logic [EW-1:0]     push_data;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // Rotate requests so bit 0 is the pointer position; lowest set bit wins.
  always_comb begin
    req_dbl      = {req_valid, req_valid};
    req_rot_full = req_dbl >> ptr_q;
    req_rot      = req_rot_full[NREQ-1:0];
    any_req      = 1'b0;
    winner       = ptr_q;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req_rot[j]) begin
        any_req = 1'b1;
        winner  = wrap_add(ptr_q, j);
      end
    end
  end

  always_comb begin
    pop   = (count_q != 2'd0) && out_ready;
    push  = inflight_q;
    // A pop in this cycle frees its slot for the result issued now.
    issue = rst_n && any_req && rnd_valid &&
            ((int'(inflight_q) + int'(count_q) - int'(pop)) < 2);

    req_ready = '0;
    rnd_ready = issue;
    sel       = issue ? winner : ptr_q;
    mul_ina0  = '0;
    mul_ina1  = '0;
    mul_inb0  = '0;
    mul_inb1  = '0;
    fl_tag_d  = fl_tag_q;
    for (int k = 0; k < NREQ; k++) begin
      if (issue && (winner == IDW'(k))) req_ready[k] = 1'b1;
      if (sel == IDW'(k)) begin
        mul_ina0 = req_a0[k*d +: d];
        mul_ina1 = req_a1[k*d +: d];
        mul_inb0 = req_b0[k*d +: d];
        mul_inb1 = req_b1[k*d +: d];
        fl_tag_d = req_tag[k*TW +: TW];
      end
    end
`ifdef MSKG4_SCHED_IDLE_ZERO_EN
    mul_rnd = issue ? rnd_in : '0;
    if (!issue) begin
      mul_ina0 = '0;
      mul_ina1 = '0;
      mul_inb0 = '0;
      mul_inb1 = '0;
    end
`else
    mul_rnd = rnd_in;
`endif

    ptr_d       = issue ? wrap_add(winner, 1) : ptr_q;
    inflight_d  = issue;
    fl_id_d     = winner;
    ina0_prev_d = mul_ina0;
    ina1_prev_d = mul_ina1;
  end

  // Gadget result stage: push into the 2-entry in-order FIFO (slot0 is the head).
  always_comb begin
    push_data = {mul_out1, mul_out0, fl_id_q, fl_tag_q};
    slot0_d   = slot0_q;
    slot1_d   = slot1_q;
    count_d   = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) slot0_d = push_data;
        else                 slot1_d = push_data;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          slot0_d = push_data;
        end else begin
          slot0_d = slot1_q;
          slot1_d = push_data;
        end
      end
      default: ;
    endcase

    out_valid = (count_q != 2'd0);
    {out1, out0, out_id, out_tag} = out_valid ? slot0_q : '0;
  end

  assign mul_ina0_prev = ina0_prev_q;
  assign mul_ina1_prev = ina1_prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      inflight_q  <= 1'b0;
      ina0_prev_q <= '0;
      ina1_prev_q <= '0;
      slot0_q     <= '0;
      slot1_q     <= '0;
      count_q     <= 2'd0;
    end else begin
      ptr_q       <= ptr_d;
      inflight_q  <= inflight_d;
      ina0_prev_q <= ina0_prev_d;
      ina1_prev_q <= ina1_prev_d;
      slot0_q     <= slot0_d;
      slot1_q     <= slot1_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    fl_id_q  <= fl_id_d;
    fl_tag_q <= fl_tag_d;
  end

endmodule

// File: tb/tb_mskg4mul_sched.sv
// Scoreboard bench for mskg4mul_sched with a behavioural latency-1 masked G(4) gadget.
module tb_mskg4mul_sched;
  localparam int D    = 2;
  localparam int NREQ = 2;
  localparam int TW   = 2;
  localparam int RW   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*D-1:0] req_a0, req_a1, req_b0, req_b1;
  logic [NREQ*TW-1:0] req_tag;
  logic [RW-1:0]     rnd_in, mul_rnd;
  logic              rnd_valid, rnd_ready;
  logic [D-1:0]      mul_ina0, mul_ina1, mul_inb0, mul_inb1, mul_ina0_prev, mul_ina1_prev;
  logic [D-1:0]      mul_out0, mul_out1, out0, out1;
  logic              out_valid, out_ready;
  logic [0:0]        out_id;
  logic [TW-1:0]     out_tag;

  mskg4mul_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .req_tag(req_tag),
    .rnd_in(rnd_in), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .mul_ina0(mul_ina0), .mul_ina1(mul_ina1), .mul_inb0(mul_inb0), .mul_inb1(mul_inb1),
    .mul_ina0_prev(mul_ina0_prev), .mul_ina1_prev(mul_ina1_prev),
    .mul_rnd(mul_rnd), .mul_out0(mul_out0), .mul_out1(mul_out1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out0(out0), .out1(out1), .out_id(out_id), .out_tag(out_tag)
  );

  // Gadget: GF(4) with x^2 = x + 1, one register stage, output remasked with rnd.
  logic [1:0]    g_a, g_b, g_c;
  logic [RW-1:0] g_r;
  always @(posedge clk) begin
    g_a <= {^mul_ina1, ^mul_ina0};
    g_b <= {^mul_inb1, ^mul_inb0};
    g_r <= mul_rnd;
  end
  assign g_c[1]   = (g_a[1] & g_b[1]) ^ (g_a[1] & g_b[0]) ^ (g_a[0] & g_b[1]);
  assign g_c[0]   = (g_a[1] & g_b[1]) ^ (g_a[0] & g_b[0]);
  assign mul_out0 = {g_r[0], g_c[0] ^ g_r[0]};
  assign mul_out1 = {g_r[1], g_c[1] ^ g_r[1]};

  typedef struct packed {
    logic [0:0] id;
    logic [1:0] tag;
    logic [1:0] p;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [0:0] id, input logic [1:0] tag, input logic [1:0] p);
    exp_t e;
    e.id = id; e.tag = tag; e.p = p;
    sb.push_back(e);
  endtask

  // Shares per bit: {mask, bit ^ mask}; m = {b1 mask, b0 mask, a1 mask, a0 mask}.
  task automatic set_req(input int k, input logic [1:0] a, input logic [1:0] b,
                         input logic [1:0] tag, input logic [3:0] m);
    req_a0[k*D +: D]   = {m[0], a[0] ^ m[0]};
    req_a1[k*D +: D]   = {m[1], a[1] ^ m[1]};
    req_b0[k*D +: D]   = {m[2], b[0] ^ m[2]};
    req_b1[k*D +: D]   = {m[3], b[1] ^ m[3]};
    req_tag[k*TW +: TW] = tag;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got id %0d tag %0d, no result pending", out_id, out_tag);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_id", 32'(out_id), 32'(e.id));
        chk("out_tag", 32'(out_tag), 32'(e.tag));
        chk("out_prod", 32'({^out1, ^out0}), 32'(e.p));
      end
    end else if (rst_n && !out_valid) begin
      chk("empty_zero", 32'({out0, out1, out_id, out_tag}), 32'd0);
    end
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; rnd_valid = 1'b0; rnd_in = '0; out_ready = 1'b1;
    req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0; req_tag = '0;
    repeat (2) @(posedge clk);
    #1 req_valid = 2'b11; rnd_valid = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rnd_ready", 32'(rnd_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_prev0", 32'(mul_ina0_prev), 32'd0);
    step();
    rst_n = 1'b1; req_valid = '0;

    // Single op from requester 0: a=3, b=0, product 0.
    step();
    set_req(0, 2'b11, 2'b00, 2'd2, 4'b0110);
    set_req(1, 2'b10, 2'b11, 2'd3, 4'b1011);
    rnd_in = 8'h5A; req_valid = 2'b01;
    push(1'b0, 2'd2, 2'd0);
    @(negedge clk);
    chk("t1_req_ready", 32'(req_ready), 32'h1);
    chk("t1_rnd_ready", 32'(rnd_ready), 32'h1);
    chk("t1_ina0", 32'(mul_ina0), 32'h1);
    chk("t1_inb0", 32'(mul_inb0), 32'h3);
    chk("t1_rnd", 32'(mul_rnd), 32'h5A);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("t1_prev0", 32'(mul_ina0_prev), 32'h1);
    chk("t1_prev1", 32'(mul_ina1_prev), 32'h2);
    chk("t1_early_valid", 32'(out_valid), 32'h0);
    chk("t1_idle_rnd_ready", 32'(rnd_ready), 32'h0);
    step();
    @(negedge clk);
    chk("t1_latency", 32'(out_valid), 32'h1);
    step();

    // Requester 1 alone: a=2, b=3, product 1.
    req_valid = 2'b10;
    push(1'b1, 2'd3, 2'd1);
    @(negedge clk);
    chk("t1b_req_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    repeat (3) step();

    // Fairness: req0 2*2=3 tag1, req1 3*3=2 tag3.
    set_req(0, 2'b10, 2'b10, 2'd1, 4'b1100);
    set_req(1, 2'b11, 2'b11, 2'd3, 4'b0011);
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) push(1'b0, 2'd1, 2'd3);
      else            push(1'b1, 2'd3, 2'd2);
      @(negedge clk);
      chk("fair_grant", 32'(req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
      step();
    end
    req_valid = '0;
    repeat (3) step();

    // Backpressure: req0 1*3=3 tag0, req1 3*2=1 tag2.
    set_req(0, 2'b01, 2'b11, 2'd0, 4'b0101);
    set_req(1, 2'b11, 2'b10, 2'd2, 4'b1010);
    out_ready = 1'b0; req_valid = 2'b11;
    push(1'b0, 2'd0, 2'd3);
    push(1'b1, 2'd2, 2'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_grant", 32'(req_ready), (i == 0) ? 32'h1 : ((i == 1) ? 32'h2 : 32'h0));
      step();
    end
    out_ready = 1'b1;
    push(1'b0, 2'd0, 2'd3);
    @(negedge clk);
    chk("bp_resume", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    repeat (4) step();

    // Randomness stall: pointer is at 1 and must stay there.
    req_valid = 2'b11; rnd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_req_ready", 32'(req_ready), 32'h0);
      chk("stall_rnd_ready", 32'(rnd_ready), 32'h0);
      step();
    end
    rnd_valid = 1'b1;
    push(1'b1, 2'd2, 2'd1);
    @(negedge clk);
    chk("stall_grant", 32'(req_ready), 32'h2);
    chk("stall_rnd_ready_on", 32'(rnd_ready), 32'h1);
    step();
    req_valid = '0;
    repeat (3) step();

    // Reset mid-flight: the op issued just before reset must vanish.
    set_req(0, 2'b10, 2'b11, 2'd1, 4'b0000);
    req_valid = 2'b01;
    @(negedge clk);
    chk("rmf_issue", 32'(req_ready), 32'h1);
    step();
    req_valid = '0; rst_n = 1'b0;
    step();
    req_valid = 2'b11;
    @(negedge clk);
    chk("rmf_rst_req_ready", 32'(req_ready), 32'h0);
    chk("rmf_rst_out_valid", 32'(out_valid), 32'h0);
    chk("rmf_rst_prev0", 32'(mul_ina0_prev), 32'h0);
    step();
    rst_n = 1'b1;
    set_req(0, 2'b01, 2'b11, 2'd0, 4'b0101);
    push(1'b0, 2'd0, 2'd3);
    @(negedge clk);
    chk("rmf_post_grant", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    repeat (3) step();

    // Idle cycle between ops: req0 3*1=3 tag1; req1 holds distinct operands.
    set_req(0, 2'b11, 2'b01, 2'd1, 4'b0000);
    set_req(1, 2'b10, 2'b10, 2'd2, 4'b0001);
    rnd_in = 8'hC3; req_valid = 2'b01;
    push(1'b0, 2'd1, 2'd3);
    @(negedge clk);
    chk("idle_grant", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    @(negedge clk);
`ifdef MSKG4_SCHED_IDLE_ZERO_EN
    chk("idle_ina0", 32'(mul_ina0), 32'h0);
    chk("idle_ina1", 32'(mul_ina1), 32'h0);
    chk("idle_inb0", 32'(mul_inb0), 32'h0);
    chk("idle_inb1", 32'(mul_inb1), 32'h0);
    chk("idle_rnd", 32'(mul_rnd), 32'h0);
`else
    chk("idle_ina0", 32'(mul_ina0), 32'h3);
    chk("idle_ina1", 32'(mul_ina1), 32'h1);
    chk("idle_inb0", 32'(mul_inb0), 32'h0);
    chk("idle_inb1", 32'(mul_inb1), 32'h1);
    chk("idle_rnd", 32'(mul_rnd), 32'hC3);
`endif
    step();
    @(negedge clk);
`ifdef MSKG4_SCHED_IDLE_ZERO_EN
    chk("idle_prev0", 32'(mul_ina0_prev), 32'h0);
    chk("idle_prev1", 32'(mul_ina1_prev), 32'h0);
`else
    chk("idle_prev0", 32'(mul_ina0_prev), 32'h3);
    chk("idle_prev1", 32'(mul_ina1_prev), 32'h1);
`endif
    repeat (4) step();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
